spi_master_gen: RTL and testbench

//  Parametrised successor of the current SPI engine: one SPI master with configurable

---
 rtl/spi_master_gen_if.sv | 35 +++
 rtl/spi_master_gen.sv | 139 +++++++++++++
 tb/tb_spi_master_gen.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_gen_if.sv
// rtl/spi_master_gen_if.sv - control, status and pin bundle for spi_master_gen
interface spi_master_gen_if #(
   parameter int DATA_W = 32,
   parameter int NUM_CS = 4,
   parameter int DIV_W  = 8,
   parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
);
   logic              start;
   logic              abort;
   logic [DATA_W-1:0] din;
   logic              cpol;
   logic              cpha;
   logic              lsb_first;
   logic [DIV_W-1:0]  clk_div;
   logic [CS_W-1:0]   cs_sel;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] dout;
   logic              miso;
   logic              mosi;
   logic              sck;
   logic [NUM_CS-1:0] cs_n;

   // SPI engine side
   modport master (
      input  start, abort, din, cpol, cpha, lsb_first, clk_div, cs_sel, miso,
      output busy, done, dout, mosi, sck, cs_n
   );

   // register logic / pin side
   modport slave (
      output start, abort, din, cpol, cpha, lsb_first, clk_div, cs_sel, miso,
      input  busy, done, dout, mosi, sck, cs_n
   );
endinterface

// File: rtl/spi_master_gen.sv
// rtl/spi_master_gen.sv - parametrised SPI master, all CPOL/CPHA modes, abortable
module spi_master_gen #(
   parameter int DATA_W = 32,
   parameter int NUM_CS = 4,
   parameter int DIV_W  = 8
) (
   input  logic            clk,
   input  logic            rst,
   spi_master_gen_if.master bus
);
   localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
   localparam int EDGES = 2 * DATA_W;
   localparam int EC_W  = $clog2(EDGES);

   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

   state_t            state;
   logic [DIV_W-1:0]  div_cnt;
   logic [DIV_W-1:0]  div_q;
   logic [EC_W-1:0]   edge_cnt;
   logic              cpol_q;
   logic              cpha_q;
   logic              lsb_q;
   logic [DATA_W-1:0] tx_q;
   logic [DATA_W-1:0] rx_q;
   logic [DATA_W-1:0] dout_q;
   logic              busy_q;
   logic              done_q;
   logic              mosi_q;
   logic              sck_q;
   logic [NUM_CS-1:0] cs_n_q;

   logic              last_edge;
   logic              sample_edge;
   logic              shift_edge;
   logic [DATA_W-1:0] tx_next;
   logic [NUM_CS-1:0] cs_dec;

   // One-hot active-low select; an out-of-range index leaves every line high
   always_comb begin
      cs_dec = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (bus.cs_sel == CS_W'(i)) cs_dec[i] = 1'b0;
      end
   end

   // Edge classification: even edges are leading; cpha picks which kind samples.
   // The first drive for cpha=1 is already on mosi from accept, so edge 0 does not shift.
   always_comb begin
      last_edge   = (edge_cnt == EC_W'(EDGES - 1));
      sample_edge = (edge_cnt[0] == cpha_q);
      shift_edge  = (edge_cnt[0] != cpha_q) && (cpha_q ? (edge_cnt != '0) : !last_edge);
      tx_next     = lsb_q ? (tx_q >> 1) : (tx_q << 1);
   end

   // Transfer sequencer: latch config on accept, pace half-periods, shift both directions
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         div_cnt  <= '0;
         div_q    <= '0;
         edge_cnt <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         lsb_q    <= 1'b0;
         tx_q     <= '0;
         rx_q     <= '0;
         dout_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         mosi_q   <= 1'b0;
         sck_q    <= 1'b0;
         cs_n_q   <= '1;
      end else begin
         done_q <= 1'b0;
         if (state == IDLE) begin
            sck_q    <= bus.cpol;
            div_cnt  <= '0;
            edge_cnt <= '0;
            if (bus.start) begin
               state  <= SETUP;
               busy_q <= 1'b1;
               cs_n_q <= cs_dec;
               cpol_q <= bus.cpol;
               cpha_q <= bus.cpha;
               lsb_q  <= bus.lsb_first;
               div_q  <= bus.clk_div;
               tx_q   <= bus.din;
               mosi_q <= bus.lsb_first ? bus.din[0] : bus.din[DATA_W-1];
            end
         end else if (bus.abort) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            cs_n_q   <= '1;
            sck_q    <= cpol_q;
            div_cnt  <= '0;
            edge_cnt <= '0;
         end else if (div_cnt != div_q) begin
            div_cnt <= div_cnt + DIV_W'(1);
         end else begin
            div_cnt <= '0;
            case (state)
               SETUP: state <= XFER;
               XFER: begin
                  sck_q <= ~sck_q;
                  if (sample_edge) begin
                     rx_q <= lsb_q ? {bus.miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], bus.miso};
                  end
                  if (shift_edge) begin
                     tx_q   <= tx_next;
                     mosi_q <= lsb_q ? tx_next[0] : tx_next[DATA_W-1];
                  end
                  if (last_edge) begin
                     state    <= HOLD;
                     edge_cnt <= '0;
                  end else begin
                     edge_cnt <= edge_cnt + EC_W'(1);
                  end
               end
               HOLD: begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  cs_n_q <= '1;
                  dout_q <= rx_q;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.dout = dout_q;
   assign bus.mosi = mosi_q;
   assign bus.sck  = sck_q;
   assign bus.cs_n = cs_n_q;
endmodule

// File: tb/tb_spi_master_gen.sv
// tb/tb_spi_master_gen.sv - randomized self-checking bench for spi_master_gen
module tb_spi_master_gen;
   localparam int DATA_W = 8;
   localparam int NUM_CS = 2;
   localparam int DIV_W  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;

   spi_master_gen_if #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .DIV_W(DIV_W)) bus ();
   spi_master_gen_if #(.DATA_W(DATA_W), .NUM_CS(3), .DIV_W(DIV_W)) bus3 ();

   spi_master_gen #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .DIV_W(DIV_W)) u_dut (
      .clk(clk), .rst(rst), .bus(bus.master)
   );

   spi_master_gen #(.DATA_W(DATA_W), .NUM_CS(3), .DIV_W(DIV_W)) u_dut3 (
      .clk(clk), .rst(rst), .bus(bus3.master)
   );

   // 100 MHz system clock
   always #5 clk = ~clk;

   // Slave model state (written by the stimulus side)
   bit         mon_en = 1'b0;
   bit         loopback = 1'b0;
   logic       m_cpol = 1'b0;
   logic       m_cpha = 1'b0;
   logic       m_lsb = 1'b0;
   logic [7:0] m_word = 8'h00;
   logic [1:0] exp_cs = 2'b11;
   logic [7:0] last_dout = 8'h00;

   // Slave model state (written by the monitor)
   bit         was_en = 1'b0;
   logic       last_sck = 1'b0;
   logic       slave_miso = 1'b0;
   int         m_edges = 0;
   int         m_lead = 0;
   int         m_trail = 0;
   int         m_samples = 0;
   logic [7:0] mosi_obs = 8'h00;
   int         e3 = 0;

   // Results of the last transfer
   int         r_lat;
   int         r_cs_bad;
   logic       r_first_mosi;
   logic       r_sck1;
   logic       r_idle_sck;

   assign bus.miso  = loopback ? bus.mosi : slave_miso;
   assign bus3.miso = bus3.mosi;

   function automatic logic bit_at(input logic [7:0] w, input logic lsbf, input int k);
      return lsbf ? w[k] : w[7-k];
   endfunction

   // SPI slave: shifts its word out on its drive edges and captures mosi on its sample edges
   always @(bus.sck or mon_en) begin
      if (mon_en && !was_en) begin
         m_edges = 0; m_lead = 0; m_trail = 0; m_samples = 0; mosi_obs = 8'h00;
         slave_miso = bit_at(m_word, m_lsb, 0);
      end else if (mon_en && bus.sck !== last_sck) begin
         m_edges++;
         if (bus.sck !== m_cpol) begin
            m_lead++;
            if (!m_cpha) begin
               if (m_samples < 8) begin
                  if (m_lsb) mosi_obs[m_samples] = bus.mosi; else mosi_obs[7-m_samples] = bus.mosi;
                  m_samples++;
               end
            end else if (m_lead <= 8) begin
               slave_miso = bit_at(m_word, m_lsb, m_lead - 1);
            end
         end else begin
            m_trail++;
            if (m_cpha) begin
               if (m_samples < 8) begin
                  if (m_lsb) mosi_obs[m_samples] = bus.mosi; else mosi_obs[7-m_samples] = bus.mosi;
                  m_samples++;
               end
            end else if (m_trail < 8) begin
               slave_miso = bit_at(m_word, m_lsb, m_trail);
            end
         end
      end
      was_en = mon_en;
      last_sck = bus.sck;
   end

   // SCK edge counter for the three-select instance
   always @(bus3.sck) e3++;

   function automatic int exp_lat(input int div);
      return 1 + (2 * DATA_W + 2) * (div + 1);
   endfunction

   task automatic start_xfer(input logic [7:0] d, input logic pol, input logic pha, input logic lsbf,
                             input logic [7:0] div, input logic cs, input logic [7:0] sw, input bit lb);
      mon_en = 1'b0;
      bus.din = d; bus.cpol = pol; bus.cpha = pha; bus.lsb_first = lsbf;
      bus.clk_div = div; bus.cs_sel = cs;
      m_word = sw; m_cpol = pol; m_cpha = pha; m_lsb = lsbf; loopback = lb;
      exp_cs = cs ? 2'b01 : 2'b10;
      @(posedge clk); #1;
      r_idle_sck = bus.sck;
      mon_en = 1'b1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      r_first_mosi = bus.mosi;
      r_sck1 = bus.sck;
   endtask

   task automatic wait_done(input int inject_cyc, input logic [7:0] inject_din);
      int cyc;
      cyc = 1;
      r_cs_bad = 0;
      while (bus.done !== 1'b1 && cyc < 400) begin
         if (bus.busy === 1'b1 && bus.cs_n !== exp_cs) r_cs_bad++;
         if (cyc == inject_cyc) begin
            bus.din = inject_din;
            bus.start = 1'b1;
         end
         @(posedge clk); #1;
         bus.start = 1'b0;
         cyc++;
      end
      r_lat = cyc;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
      checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", bus.dout); end
      checks++; if (bus.mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", bus.mosi); end
      checks++; if (bus.sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b want 0", bus.sck); end
      checks++; if (bus.cs_n !== 2'b11) begin errors++; $display("FAIL reset_cs_n: got %b want 11", bus.cs_n); end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.cs_n !== 2'b11) begin
         errors++; $display("FAIL idle_after_reset: busy=%b cs_n=%b want 0/11", bus.busy, bus.cs_n);
      end
   endtask

   task automatic test_mode0_loopback();
      start_xfer(8'hA5, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 8'h00, 1'b1);
      wait_done(0, 8'h00);
      checks++; if (r_idle_sck !== 1'b0) begin errors++; $display("FAIL m0_idle_sck: got %b want 0", r_idle_sck); end
      checks++; if (r_lat !== 37) begin errors++; $display("FAIL m0_latency: got %0d want 37", r_lat); end
      checks++; if (mosi_obs !== 8'hA5) begin errors++; $display("FAIL m0_mosi: got %h want a5", mosi_obs); end
      checks++; if (bus.dout !== 8'hA5) begin errors++; $display("FAIL m0_dout: got %h want a5", bus.dout); end
      checks++; if (r_cs_bad !== 0) begin errors++; $display("FAIL m0_cs_n: %0d busy cycles not 10", r_cs_bad); end
      checks++; if (m_edges !== 16) begin errors++; $display("FAIL m0_edges: got %0d want 16", m_edges); end
      checks++; if (bus.cs_n !== 2'b11 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL m0_done_state: cs_n=%b busy=%b want 11/0", bus.cs_n, bus.busy);
      end
      last_dout = 8'hA5;
   endtask

   task automatic test_abort();
      int cyc;
      int done_seen;
      logic pol;
      pol = 1'($urandom_range(0, 1));
      start_xfer(8'($urandom), pol, 1'b0, 1'($urandom_range(0, 1)), 8'd1, 1'b0, 8'($urandom), 1'b0);
      cyc = 0;
      while (m_edges < 5 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++; if (m_edges !== 5) begin errors++; $display("FAIL abort_reach_edge5: edges=%0d want 5", m_edges); end
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      checks++; if (bus.cs_n !== 2'b11) begin errors++; $display("FAIL abort_cs_n: got %b want 11", bus.cs_n); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
      checks++; if (bus.sck !== pol) begin errors++; $display("FAIL abort_sck: got %b want %b", bus.sck, pol); end
      done_seen = 0;
      repeat (60) begin
         if (bus.done === 1'b1) done_seen++;
         @(posedge clk); #1;
      end
      checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done: %0d done pulses want 0", done_seen); end
      checks++; if (bus.dout !== last_dout) begin errors++; $display("FAIL abort_dout: got %h want %h", bus.dout, last_dout); end
   endtask

   task automatic test_abort_idle();
      logic [7:0] d;
      d = 8'($urandom);
      bus.abort = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++; $display("FAIL abort_idle_noop: busy=%b done=%b want 0/0", bus.busy, bus.done);
      end
      start_xfer(d, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'h00, 1'b1);
      bus.abort = 1'b0;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_with_start: busy=%b want 1", bus.busy); end
      wait_done(0, 8'h00);
      checks++; if (r_lat !== exp_lat(0) || bus.dout !== d) begin
         errors++; $display("FAIL div0_xfer: lat=%0d dout=%h want %0d/%h", r_lat, bus.dout, exp_lat(0), d);
      end
   endtask

   task automatic test_back_to_back();
      start_xfer(8'hA5, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 8'h00, 1'b1);
      wait_done(10, 8'h3C);
      checks++; if (r_lat !== 37) begin errors++; $display("FAIL b2b_first_latency: got %0d want 37", r_lat); end
      checks++; if (mosi_obs !== 8'hA5) begin errors++; $display("FAIL b2b_ignored_start_mosi: got %h want a5", mosi_obs); end
      checks++; if (bus.dout !== 8'hA5) begin errors++; $display("FAIL b2b_first_dout: got %h want a5", bus.dout); end
      bus.din = 8'h3C;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++; if (bus.busy !== 1'b1 || bus.cs_n !== 2'b10) begin
         errors++; $display("FAIL b2b_chain_accept: busy=%b cs_n=%b want 1/10", bus.busy, bus.cs_n);
      end
      wait_done(0, 8'h00);
      checks++; if (r_lat !== 37 || bus.dout !== 8'h3C) begin
         errors++; $display("FAIL b2b_second: lat=%0d dout=%h want 37/3c", r_lat, bus.dout);
      end
   endtask

   task automatic test_mode3_lsb();
      start_xfer(8'h01, 1'b1, 1'b1, 1'b1, 8'd3, 1'b1, 8'hFF, 1'b0);
      wait_done(0, 8'h00);
      checks++; if (r_idle_sck !== 1'b1 || r_sck1 !== 1'b1) begin
         errors++; $display("FAIL m3_sck_idle: idle=%b setup=%b want 1/1", r_idle_sck, r_sck1);
      end
      checks++; if (r_first_mosi !== 1'b1) begin errors++; $display("FAIL m3_first_mosi: got %b want 1", r_first_mosi); end
      checks++; if (r_lat !== 73) begin errors++; $display("FAIL m3_latency: got %0d want 73", r_lat); end
      checks++; if (bus.dout !== 8'hFF) begin errors++; $display("FAIL m3_dout: got %h want ff", bus.dout); end
      checks++; if (r_cs_bad !== 0) begin errors++; $display("FAIL m3_cs_n: %0d busy cycles not 01", r_cs_bad); end
      checks++; if (mosi_obs !== 8'h01) begin errors++; $display("FAIL m3_mosi: got %h want 01", mosi_obs); end
   endtask

   task automatic test_mode1_slave();
      logic [7:0] d;
      d = 8'($urandom);
      start_xfer(d, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 8'h5A, 1'b0);
      wait_done(0, 8'h00);
      checks++; if (bus.dout !== 8'h5A) begin errors++; $display("FAIL m1_dout: got %h want 5a", bus.dout); end
      checks++; if (mosi_obs !== d) begin errors++; $display("FAIL m1_mosi: got %h want %h", mosi_obs, d); end
      checks++; if (r_lat !== 37) begin errors++; $display("FAIL m1_latency: got %0d want 37", r_lat); end
   endtask

   task automatic test_cs_out_of_range();
      logic [7:0] d;
      int e0;
      int cyc;
      int bad;
      d = 8'($urandom);
      bus3.din = d; bus3.cpol = 1'b0; bus3.cpha = 1'b1; bus3.lsb_first = 1'b0;
      bus3.clk_div = 8'd1; bus3.cs_sel = 2'd3;
      @(posedge clk); #1;
      e0 = e3;
      bus3.start = 1'b1;
      @(posedge clk); #1;
      bus3.start = 1'b0;
      cyc = 1;
      bad = 0;
      while (bus3.done !== 1'b1 && cyc < 400) begin
         if (bus3.cs_n !== 3'b111) bad++;
         @(posedge clk); #1;
         cyc++;
      end
      checks++; if (cyc !== 37) begin errors++; $display("FAIL oor_done_latency: got %0d want 37", cyc); end
      checks++; if (e3 - e0 !== 16) begin errors++; $display("FAIL oor_edges: got %0d want 16", e3 - e0); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL oor_cs_n: %0d cycles with a select low", bad); end
      checks++; if (bus3.dout !== d) begin errors++; $display("FAIL oor_dout: got %h want %h", bus3.dout, d); end
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic [7:0] sw;
      logic [7:0] div;
      logic [7:0] want;
      logic pol, pha, lsbf, cs;
      bit lb;
      for (int n = 0; n < 8; n++) begin
         d = 8'($urandom); sw = 8'($urandom); div = 8'($urandom_range(0, 3));
         pol = 1'($urandom_range(0, 1)); pha = 1'($urandom_range(0, 1));
         lsbf = 1'($urandom_range(0, 1)); cs = 1'($urandom_range(0, 1));
         lb = 1'($urandom_range(0, 1));
         want = lb ? d : sw;
         start_xfer(d, pol, pha, lsbf, div, cs, sw, lb);
         wait_done(0, 8'h00);
         checks++; if (r_lat !== exp_lat(int'(div))) begin
            errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, r_lat, exp_lat(int'(div)));
         end
         checks++; if (bus.dout !== want) begin errors++; $display("FAIL rnd%0d_dout: got %h want %h", n, bus.dout, want); end
         checks++; if (mosi_obs !== d) begin errors++; $display("FAIL rnd%0d_mosi: got %h want %h", n, mosi_obs, d); end
         checks++; if (m_edges !== 16) begin errors++; $display("FAIL rnd%0d_edges: got %0d want 16", n, m_edges); end
         checks++; if (r_cs_bad !== 0) begin errors++; $display("FAIL rnd%0d_cs_n: %0d bad busy cycles", n, r_cs_bad); end
         checks++; if (bus.sck !== pol) begin errors++; $display("FAIL rnd%0d_sck_end: got %b want %b", n, bus.sck, pol); end
      end
   endtask

   task automatic test_rst_mid();
      start_xfer(8'($urandom), 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 8'h00, 1'b1);
      repeat (10) @(posedge clk);
      #3;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", bus.busy); end
      rst = 1'b1;
      #1;
      checks++; if (bus.cs_n !== 2'b11) begin errors++; $display("FAIL rstmid_cs_n: got %b want 11", bus.cs_n); end
      checks++; if (bus.sck !== 1'b0) begin errors++; $display("FAIL rstmid_sck: got %b want 0", bus.sck); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
      checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL rstmid_dout: got %h want 00", bus.dout); end
      @(posedge clk); #1;
      rst = 1'b0;
      mon_en = 1'b0;
   endtask

   // Scenario sequence
   initial begin
      bus.start = 1'b0; bus.abort = 1'b0; bus.din = '0; bus.cpol = 1'b0; bus.cpha = 1'b0;
      bus.lsb_first = 1'b0; bus.clk_div = '0; bus.cs_sel = '0;
      bus3.start = 1'b0; bus3.abort = 1'b0; bus3.din = '0; bus3.cpol = 1'b0; bus3.cpha = 1'b0;
      bus3.lsb_first = 1'b0; bus3.clk_div = '0; bus3.cs_sel = '0;
      test_reset();
      test_mode0_loopback();
      test_abort();
      test_abort_idle();
      test_back_to_back();
      test_mode3_lsb();
      test_mode1_slave();
      test_cs_out_of_range();
      test_random();
      test_rst_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
